mode_controller: RTL and testbench

MODE_CONTROLLER -- requirements
Module: mode_controller

---
 rtl/mode_controller.sv | 181 ++++++++++++++++++
 tb/tb_mode_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_controller.sv
// mode_controller
// Selects the display mode of a clock from a bank of active-low mode buttons
// and a SETUP request level. Every asynchronous input goes through a 2-flop
// synchroniser. Each button then has its own debounce counter, and each
// accepted press becomes a one-cycle event. A small mode state machine
// (saved run mode plus the visible mode) turns those events into a
// registered mode, an in_setup flag and a one-cycle mode_change pulse.
//
// Latency from the first clock edge that samples a new input level:
//   setUp   : 3 edges  (2 synchroniser edges + mode register)
//   button  : DEBOUNCE_CYC + 3 edges
//             (2 synchroniser edges + DEBOUNCE_CYC qualification edges,
//              which end by registering the press event, + mode register)

module mode_controller #(
  parameter int NUM_BTN      = 4,
  parameter int MODE_W       = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int RESET_MODE   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               setUp,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [MODE_W-1:0]  mode,
  output logic               in_setup,
  output logic               mode_change
);

  // Highest run mode code. Button i selects run mode i+1, so only buttons
  // with index below MAX_RUN map to a mode.
  localparam int MAX_RUN = (1 << MODE_W) - 1;

  // The debounce counter is wide enough for the full 1..255 DEBOUNCE_CYC
  // range. A counter value of CNT_LAST means that the level has already
  // been stable for DEBOUNCE_CYC-1 cycles, so the current cycle completes
  // the qualification.
  localparam int             CNT_W    = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [MODE_W-1:0] RST_MODE = MODE_W'(RESET_MODE);

  // ---------------------------------------------------------------------
  // Synchroniser stage: _p0 is the metastability flop and _p1 is the
  // first copy that is safe to use. On reset the button flops load 1
  // (released) and the setUp flops load 0 (not requested). Because of
  // this, a button that is still held when reset ends must go through a
  // complete new debounce.
  // ---------------------------------------------------------------------
  logic               r_setup_p0;
  logic               r_setup_p1;
  logic [NUM_BTN-1:0] r_btn_p0;
  logic [NUM_BTN-1:0] r_btn_p1;

  // Two-flop synchroniser for setUp and every button bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_setup_p0 <= 1'b0;
      r_setup_p1 <= 1'b0;
      r_btn_p0   <= '1;
      r_btn_p1   <= '1;
    end else begin
      r_setup_p0 <= setUp;
      r_setup_p1 <= r_setup_p0;
      r_btn_p0   <= buttons;
      r_btn_p1   <= r_btn_p0;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce stage: r_btn_state is the accepted level (1 = released).
  // When the synchronised level differs from the accepted level, that
  // new level is being qualified. When the synchronised level matches
  // the accepted level, any partial qualification is a bounce and the
  // counter is cleared. A press event is raised only on the
  // released->pressed transition, so a held button gives exactly one
  // event.
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] r_btn_state;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_press_p2;

  // Per-button debounce counters, accepted levels and press events
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_state <= '1;
      r_press_p2  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_press_p2[i] <= 1'b0;
        if (r_btn_p1[i] == r_btn_state[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_btn_state[i] <= r_btn_p1[i];
          r_cnt[i]       <= '0;
          r_press_p2[i]  <= ~r_btn_p1[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press selection: this is combinational on the registered press
  // events. Among the mapped buttons, the lowest index wins. Buttons at
  // or above MAX_RUN are still debounced, but they never select a mode.
  // ---------------------------------------------------------------------
  logic              w_sel_vld;
  logic [MODE_W-1:0] w_sel_mode;

  // Lowest-index priority encoder over the mapped press events
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_mode = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if ((i < MAX_RUN) && r_press_p2[i]) begin
        w_sel_vld  = 1'b1;
        w_sel_mode = MODE_W'(i + 1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mode state machine. The state has two parts: the saved run mode, and
  // the visible mode, which is either 0 (SETUP) or the saved run mode.
  // In SETUP, press events are dropped and are not queued. When setUp
  // falls, the visible mode goes back to the saved run mode, which
  // SETUP did not change.
  // ---------------------------------------------------------------------
  logic [MODE_W-1:0] r_mode;
  logic [MODE_W-1:0] r_saved_mode;
  logic              r_in_setup;
  logic              r_mode_change;

  logic [MODE_W-1:0] w_mode_nxt;
  logic [MODE_W-1:0] w_saved_nxt;
  logic              w_in_setup_nxt;
  logic              w_mode_change_nxt;

  // State register: mode, saved run mode and the registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode        <= RST_MODE;
      r_saved_mode  <= RST_MODE;
      r_in_setup    <= 1'b0;
      r_mode_change <= 1'b0;
    end else begin
      r_mode        <= w_mode_nxt;
      r_saved_mode  <= w_saved_nxt;
      r_in_setup    <= w_in_setup_nxt;
      r_mode_change <= w_mode_change_nxt;
    end
  end

  // Next state: a press outside setup updates the run mode; setup overrides
  always_comb begin
    w_saved_nxt = r_saved_mode;
    if (!r_setup_p1 && w_sel_vld) begin
      w_saved_nxt = w_sel_mode;
    end
    if (r_setup_p1) begin
      w_mode_nxt = '0;
    end else begin
      w_mode_nxt = w_saved_nxt;
    end
  end

  // Output decode: setup flag and change pulse for the next mode value
  always_comb begin
    w_in_setup_nxt    = (w_mode_nxt == '0);
    w_mode_change_nxt = (w_mode_nxt != r_mode);
  end

  assign mode        = r_mode;
  assign in_setup    = r_in_setup;
  assign mode_change = r_mode_change;

endmodule

// File: tb/tb_mode_controller.sv
// Directed testbench for mode_controller. It has two instances:
// u_dut uses the default parameters, and u_dut_w uses MODE_W=3,
// NUM_BTN=8 and DEBOUNCE_CYC=1. Inputs change 1 ns after a rising edge,
// and outputs are sampled at that same point, so the Nth tick() after an
// input change shows the result of edge N.

module tb_mode_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       setUp;
  logic [3:0] buttons;
  logic [1:0] mode;
  logic       in_setup;
  logic       mode_change;

  logic       setUp_w;
  logic [7:0] buttons_w;
  logic [2:0] mode_w;
  logic       in_setup_w;
  logic       mode_change_w;

  int n_cmp    = 0;
  int n_err    = 0;
  int pulses   = 0;
  int pulses_w = 0;

  always #5 clk = ~clk;

  mode_controller u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .setUp       (setUp),
    .buttons     (buttons),
    .mode        (mode),
    .in_setup    (in_setup),
    .mode_change (mode_change)
  );

  mode_controller #(
    .NUM_BTN      (8),
    .MODE_W       (3),
    .DEBOUNCE_CYC (1),
    .RESET_MODE   (1)
  ) u_dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .setUp       (setUp_w),
    .buttons     (buttons_w),
    .mode        (mode_w),
    .in_setup    (in_setup_w),
    .mode_change (mode_change_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 ns later, counting change pulses
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mode_change === 1'b1)   pulses++;
      if (mode_change_w === 1'b1) pulses_w++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    setUp     = 1'b0;
    buttons   = 4'hF;
    setUp_w   = 1'b0;
    buttons_w = 8'hFF;
    tick(2);
    chk("rst_mode",      mode, 1);
    chk("rst_in_setup",  in_setup, 0);
    chk("rst_chg",       mode_change, 0);
    chk("rst_mode_w",    mode_w, 1);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_mode", mode, 1);

    // Clean press of button1: mode 2 appears at edge 7 and pulses once
    pulses  = 0;
    buttons = 4'b1101;
    tick(6);
    chk("press_e6_mode",  mode, 1);
    chk("press_e6_pulse", pulses, 0);
    tick(1);
    chk("press_e7_mode",  mode, 2);
    chk("press_e7_chg",   mode_change, 1);
    tick(1);
    chk("press_e8_chg",   mode_change, 0);
    pulses = 0;
    tick(50);
    chk("hold_pulses",    pulses, 0);
    chk("hold_mode",      mode, 2);
    buttons = 4'hF;
    tick(8);
    chk("release_mode",   mode, 2);

    // Return to mode 1 with button0
    buttons = 4'b1110;
    tick(7);
    chk("btn0_mode", mode, 1);
    buttons = 4'hF;
    tick(8);

    // Bounce on button0 (3 low, 1 high, 3 low): no acceptance
    pulses  = 0;
    buttons = 4'b1110; tick(3);
    buttons = 4'hF;    tick(1);
    buttons = 4'b1110; tick(3);
    buttons = 4'hF;    tick(8);
    chk("bounce0_mode",   mode, 1);
    chk("bounce0_pulses", pulses, 0);
    // Same bounce on button2, where an acceptance would show as mode 3
    buttons = 4'b1011; tick(3);
    buttons = 4'hF;    tick(1);
    buttons = 4'b1011; tick(3);
    buttons = 4'hF;    tick(8);
    chk("bounce2_mode",   mode, 1);
    chk("bounce2_pulses", pulses, 0);
    // Exactly 4 low cycles on button0: accepted, but mode 1 is already current
    buttons = 4'b1110; tick(4);
    buttons = 4'hF;    tick(10);
    chk("same_mode",        mode, 1);
    chk("same_mode_pulses", pulses, 0);
    // Exactly 4 low cycles on button2: accepted, so mode 3 at edge 7
    buttons = 4'b1011; tick(4);
    buttons = 4'hF;    tick(2);
    chk("min_press_e6", mode, 1);
    tick(1);
    chk("min_press_e7", mode, 3);
    chk("min_press_chg", mode_change, 1);
    tick(8);

    // Setup override from mode 3
    setUp = 1'b1;
    tick(2);
    chk("setup_e2_mode",  mode, 3);
    tick(1);
    chk("setup_e3_mode",  mode, 0);
    chk("setup_in_setup", in_setup, 1);
    chk("setup_chg",      mode_change, 1);
    pulses  = 0;
    buttons = 4'b1101;
    tick(10);
    chk("setup_press_mode", mode, 0);
    buttons = 4'hF;
    tick(8);
    chk("setup_press_pulses", pulses, 0);
    setUp = 1'b0;
    tick(2);
    chk("unsetup_e2_mode", mode, 0);
    tick(1);
    chk("unsetup_e3_mode", mode, 3);
    chk("unsetup_in_setup", in_setup, 0);
    chk("unsetup_chg",      mode_change, 1);
    tick(4);

    // Simultaneous presses: lowest index wins
    buttons = 4'b1000;
    tick(6);
    chk("simul_e6_mode", mode, 3);
    tick(1);
    chk("simul_e7_mode", mode, 1);
    chk("simul_chg",     mode_change, 1);
    buttons = 4'hF;
    tick(8);
    // Button3 is unmapped at defaults
    pulses  = 0;
    buttons = 4'b0111;
    tick(10);
    chk("btn3_mode",   mode, 1);
    chk("btn3_pulses", pulses, 0);
    buttons = 4'hF;
    tick(8);

    // Reset in the middle of debouncing button2
    buttons = 4'b1011;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("rstdb_mode", mode, 1);
    chk("rstdb_chg",  mode_change, 0);
    rst_n = 1'b1;
    tick(6);
    chk("rstdb_fresh_e6", mode, 1);
    tick(1);
    chk("rstdb_fresh_e7", mode, 3);
    chk("rstdb_fresh_chg", mode_change, 1);
    buttons = 4'hF;
    tick(8);

    // Reset during setup (saved mode is 3 before the reset)
    setUp = 1'b1;
    tick(3);
    chk("rstsu_pre_mode", mode, 0);
    rst_n = 1'b0;
    setUp = 1'b0;
    tick(1);
    chk("rstsu_mode",     mode, 1);
    chk("rstsu_in_setup", in_setup, 0);
    chk("rstsu_chg",      mode_change, 0);
    rst_n  = 1'b1;
    pulses = 0;
    tick(5);
    chk("rstsu_exit_mode",   mode, 1);
    chk("rstsu_exit_pulses", pulses, 0);

    // Parameter sweep instance: button6 gives mode 7 after 4 edges
    pulses_w  = 0;
    buttons_w = 8'b1011_1111;
    tick(3);
    chk("w_e3_mode", mode_w, 1);
    tick(1);
    chk("w_e4_mode", mode_w, 7);
    chk("w_e4_chg",  mode_change_w, 1);
    buttons_w = 8'hFF;
    tick(4);
    pulses_w  = 0;
    buttons_w = 8'b0111_1111;
    tick(6);
    chk("w_btn7_mode",   mode_w, 7);
    chk("w_btn7_pulses", pulses_w, 0);
    buttons_w = 8'hFF;
    tick(4);
    buttons_w = 8'b1111_1110;
    tick(4);
    chk("w_btn0_mode", mode_w, 1);
    buttons_w = 8'hFF;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
